// File: rtl/cc_pkg.sv
// Shared definitions for the control_circuit FSM: opcodes, ALU modes,
// time-step encoding and instruction field positions.
package cc_pkg;

   localparam int unsigned IR_W   = 11;
   localparam int unsigned OP_MSB = 10;
   localparam int unsigned OP_LSB = 8;
   localparam int unsigned RX_MSB = 7;
   localparam int unsigned RX_LSB = 4;
   localparam int unsigned RY_MSB = 3;
   localparam int unsigned RY_LSB = 0;

   localparam logic [2:0] OP_LOAD = 3'b000;
   localparam logic [2:0] OP_MOV  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;

   localparam logic [1:0] ALU_MODE_ADD = 2'b00;
   localparam logic [1:0] ALU_MODE_SUB = 2'b01;
   localparam logic [1:0] ALU_MODE_XOR = 2'b10;

   typedef enum logic [1:0] {T0, T1, T2, T3} state_e;

   // ALU mode for an arithmetic opcode; anything else maps to the idle mode.
   function automatic logic [1:0] alu_mode_of(input logic [2:0] op);
      logic [1:0] m;
      m = ALU_MODE_ADD;
      case (op)
         OP_SUB:  m = ALU_MODE_SUB;
         OP_XOR:  m = ALU_MODE_XOR;
         default: m = ALU_MODE_ADD;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/reg_decoder.sv
// 4-bit register index to one-hot enable vector, gated by an enable.
module reg_decoder #(
   parameter int unsigned N = 16
) (
   input  logic [3:0]   idx_i,
   input  logic         en_i,
   output logic [N-1:0] onehot_o
);

   // Single bit set at idx_i when enabled, all zero otherwise.
   always_comb begin
      onehot_o = '0;
      if (en_i) onehot_o[idx_i] = 1'b1;
   end

endmodule

// File: rtl/control_circuit.sv
// Multi-cycle control FSM: fetches an 11-bit instruction in T0 and sequences
// register enables, ALU strobes and Done through T1..T3 (Moore outputs).
module control_circuit
   import cc_pkg::*;
#(
   parameter int num_of_reg = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [IR_W-1:0]       INSTRUCTION,
   output logic [num_of_reg-1:0] Rin,
   output logic [num_of_reg-1:0] Rout,
   output logic                  ALU_a_in,
   output logic                  ALU_g_in,
   output logic                  ALU_g_out,
   output logic [1:0]            ALU_mode,
   output logic                  Done,
   output logic                  External_load
);

   state_e            state_q, state_d;
   logic [IR_W-1:0]   ir_q;
   logic [2:0]        op;
   logic [3:0]        rx, ry;
   logic              rin_en, rout_en;
   logic [3:0]        rin_idx, rout_idx;

   assign op = ir_q[OP_MSB:OP_LSB];
   assign rx = ir_q[RX_MSB:RX_LSB];
   assign ry = ir_q[RY_MSB:RY_LSB];

   // State register and instruction latch; IR only loads while in T0.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= T0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == T0) ir_q <= INSTRUCTION;
      end
   end

   // Next-state and Moore output decode from state and IR.
   always_comb begin
      state_d       = state_q;
      rin_en        = 1'b0;
      rin_idx       = rx;
      rout_en       = 1'b0;
      rout_idx      = rx;
      ALU_a_in      = 1'b0;
      ALU_g_in      = 1'b0;
      ALU_g_out     = 1'b0;
      ALU_mode      = ALU_MODE_ADD;
      Done          = 1'b0;
      External_load = 1'b0;
      case (state_q)
         T0: state_d = T1;
         T1: begin
            case (op)
               OP_LOAD: begin
                  rin_en        = 1'b1;
                  External_load = 1'b1;
                  Done          = 1'b1;
                  state_d       = T0;
               end
               OP_MOV: begin
                  rout_idx = ry;
                  rout_en  = 1'b1;
                  rin_en   = 1'b1;
                  Done     = 1'b1;
                  state_d  = T0;
               end
               OP_ADD, OP_SUB, OP_XOR: begin
                  rout_en  = 1'b1;
                  ALU_a_in = 1'b1;
                  state_d  = T2;
               end
               default: begin
                  Done    = 1'b1;
                  state_d = T0;
               end
            endcase
         end
         T2: begin
            rout_idx = ry;
            rout_en  = 1'b1;
            ALU_g_in = 1'b1;
            ALU_mode = alu_mode_of(op);
            state_d  = T3;
         end
         T3: begin
            ALU_g_out = 1'b1;
            rin_en    = 1'b1;
            Done      = 1'b1;
            state_d   = T0;
         end
      endcase
   end

   reg_decoder #(.N(num_of_reg)) u_rin_dec (
      .idx_i    (rin_idx),
      .en_i     (rin_en),
      .onehot_o (Rin)
   );

   reg_decoder #(.N(num_of_reg)) u_rout_dec (
      .idx_i    (rout_idx),
      .en_i     (rout_en),
      .onehot_o (Rout)
   );

endmodule

// File: tb/tb_control_circuit.sv
// Directed + random bench for control_circuit with an expected-output queue.
module tb_control_circuit;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] INSTRUCTION;
   logic [15:0] Rin, Rout;
   logic        ALU_a_in, ALU_g_in, ALU_g_out, Done, External_load;
   logic [1:0]  ALU_mode;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic [38:0] sb_q[$];

   control_circuit #(.num_of_reg(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .INSTRUCTION   (INSTRUCTION),
      .Rin           (Rin),
      .Rout          (Rout),
      .ALU_a_in      (ALU_a_in),
      .ALU_g_in      (ALU_g_in),
      .ALU_g_out     (ALU_g_out),
      .ALU_mode      (ALU_mode),
      .Done          (Done),
      .External_load (External_load)
   );

   always #5 clk = ~clk;

   // {Rin, Rout, a_in, g_in, g_out, mode, done, ext}
   function automatic logic [38:0] mk(input logic [15:0] rin, input logic [15:0] rout,
                                      input logic a, input logic g, input logic go,
                                      input logic [1:0] m, input logic d, input logic e);
      return {rin, rout, a, g, go, m, d, e};
   endfunction

   function automatic int unsigned nsteps(input logic [10:0] ins);
      return (ins[10:8] inside {3'd2, 3'd3, 3'd4}) ? 3 : 1;
   endfunction

   // Expected outputs in step s (1..3) of instruction ins.
   function automatic logic [38:0] model(input logic [10:0] ins, input int unsigned s);
      logic [2:0]  op;
      logic [15:0] ohx, ohy;
      logic [1:0]  m;
      op  = ins[10:8];
      ohx = 16'h0001 << ins[7:4];
      ohy = 16'h0001 << ins[3:0];
      m   = (op == 3'd3) ? 2'b01 : (op == 3'd4) ? 2'b10 : 2'b00;
      case (op)
         3'd0: return mk(ohx, 16'h0, 0, 0, 0, 2'b00, 1, 1);
         3'd1: return mk(ohx, ohy, 0, 0, 0, 2'b00, 1, 0);
         3'd2, 3'd3, 3'd4: begin
            if (s == 1) return mk(16'h0, ohx, 1, 0, 0, 2'b00, 0, 0);
            if (s == 2) return mk(16'h0, ohy, 0, 1, 0, m, 0, 0);
            return mk(ohx, 16'h0, 0, 0, 1, 2'b00, 1, 0);
         end
         default: return mk(16'h0, 16'h0, 0, 0, 0, 2'b00, 1, 0);
      endcase
   endfunction

   // Pop the oldest expectation and compare against the live outputs.
   task automatic check(input string tag);
      logic [38:0] obs, exp;
      obs = {Rin, Rout, ALU_a_in, ALU_g_in, ALU_g_out, ALU_mode, Done, External_load};
      vectors++;
      if (sb_q.size() == 0) begin
         miscompares++;
         $display("FAIL %s scoreboard empty observed=%h", tag, obs);
      end else begin
         exp = sb_q.pop_front();
         assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
      end
   endtask

   // Entered at a negedge in T0. Runs up to max_steps steps of ins; optionally
   // disturbs INSTRUCTION during T1 and/or asserts reset after the last step.
   task automatic run_instr(input string tag, input logic [10:0] ins,
                            input int unsigned max_steps, input bit scramble,
                            input bit abort);
      int unsigned n;
      n = nsteps(ins);
      if (max_steps < n) n = max_steps;
      sb_q.push_back('0);
      for (int unsigned s = 1; s <= n; s++) sb_q.push_back(model(ins, s));
      check({tag, "_t0"});
      INSTRUCTION = ins;
      for (int unsigned s = 1; s <= n; s++) begin
         @(posedge clk);
         @(negedge clk);
         if (scramble && s == 1) INSTRUCTION = ~ins;
         check($sformatf("%s_t%0d", tag, s));
      end
      if (abort) begin
         reset = 1'b1;
         sb_q.push_back('0);
      end
      @(posedge clk);
      @(negedge clk);
      if (abort) begin
         check({tag, "_rst"});
         reset = 1'b0;
      end
   endtask

   initial begin
      reset       = 1'b1;
      INSTRUCTION = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      sb_q.push_back('0);
      check("reset");
      reset = 1'b0;

      run_instr("load_r1_6",  11'b000_0001_0110, 3, 0, 0);
      run_instr("mov_r1_r2",  11'b001_0001_0010, 3, 1, 0);
      run_instr("add_r3_r4",  11'b010_0011_0100, 3, 1, 0);
      run_instr("sub_r2_r4",  11'b011_0010_0100, 3, 0, 0);
      run_instr("xor_r0_r3",  11'b100_0000_0011, 3, 0, 0);
      run_instr("nop_555",    11'b101_0101_0101, 3, 0, 0);
      run_instr("nop_6",      11'b110_1111_1111, 3, 0, 0);
      run_instr("nop_7",      11'b111_0000_0000, 3, 0, 0);
      run_instr("mov_r14_15", 11'b001_1110_1111, 3, 0, 0);
      run_instr("mov_r7_r7",  11'b001_0111_0111, 3, 0, 0);
      run_instr("add_r5_r5",  11'b010_0101_0101, 3, 0, 0);
      run_instr("load_r15_f", 11'b000_1111_1111, 3, 0, 0);
      run_instr("add_rst_t2", 11'b010_0011_0100, 2, 0, 1);
      run_instr("post_rst",   11'b011_1001_1010, 3, 0, 0);

      for (int i = 0; i < 24; i++) begin
         logic [10:0] r;
         r = 11'($urandom_range(0, 2047));
         run_instr($sformatf("rnd%0d", i), r, 3, i[0], 0);
      end

      if (sb_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
